// File: rtl/v2_deque_pkg.sv
// Shared types and default sizing for the v2 op-centric deque.
// Default sizes may be overridden from the build through TOP_DEPTH / TOP_CHANWIDTH.
`ifndef TOP_DEPTH
`define TOP_DEPTH 8
`endif
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 32
`endif

package v2_deque_pkg;

    localparam int unsigned DEPTH_DEFAULT = `TOP_DEPTH;
    localparam int unsigned WIDTH_DEFAULT = `TOP_CHANWIDTH;
    localparam int unsigned PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);
    localparam int unsigned CNT_W_DEFAULT = PTR_W_DEFAULT + 1;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH_BACK,
        OP_PUSH_FRONT,
        OP_POP_FRONT,
        OP_POP_BACK
    } op_e;

endpackage

// File: rtl/v2_deque_ctrl.sv
// Deque control: push/pop arbitration, head/count bookkeeping, write index and read indices.
// Storage lives in the parent; this block only decides where data goes.
module v2_deque_ctrl
    import v2_deque_pkg::*;
#(
    parameter int unsigned p_depth  = DEPTH_DEFAULT,
    localparam int unsigned lp_ptr_w = $clog2(p_depth),
    localparam int unsigned lp_cnt_w = lp_ptr_w + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_push_back_en,
    input  logic                i_push_front_en,
    input  logic                i_pop_front_en,
    input  logic                i_pop_back_en,
    output logic                o_push_rdy,
    output logic                o_pop_rdy,
    output logic                o_wr_en,
    output logic                o_wr_sel_front,
    output logic [lp_ptr_w-1:0] o_wr_idx,
    output logic [lp_ptr_w-1:0] o_rd_front_idx,
    output logic [lp_ptr_w-1:0] o_rd_back_idx,
    output logic [lp_cnt_w-1:0] o_count
);

    localparam logic [lp_ptr_w-1:0] lp_ptr_one = lp_ptr_w'(1);
    localparam logic [lp_cnt_w-1:0] lp_cnt_one = lp_cnt_w'(1);
    localparam logic [lp_cnt_w-1:0] lp_cnt_max = lp_cnt_w'(p_depth);

    logic [lp_ptr_w-1:0] r_head;
    logic [lp_cnt_w-1:0] r_count;

    op_e                 w_push_op;
    op_e                 w_pop_op;
    logic                w_push_rdy;
    logic                w_pop_rdy;
    logic [lp_ptr_w-1:0] w_count_lo;
    logic [lp_ptr_w-1:0] w_tail;
    logic [lp_ptr_w-1:0] w_head_next;
    logic [lp_ptr_w-1:0] w_wr_idx;
    logic [lp_cnt_w-1:0] w_count_next;

    // Readiness comes from registered state only, so there is no en->rdy path.
    assign w_push_rdy = (r_count != lp_cnt_max);
    assign w_pop_rdy  = (r_count != '0);
    assign w_count_lo = r_count[lp_ptr_w-1:0];
    assign w_tail     = r_head + w_count_lo - lp_ptr_one;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_push_op = OP_NONE;
        w_pop_op  = OP_NONE;
        if (!i_clear) begin
            if (w_push_rdy) begin
                if (i_push_back_en)       w_push_op = OP_PUSH_BACK;
                else if (i_push_front_en) w_push_op = OP_PUSH_FRONT;
            end
            if (w_pop_rdy) begin
                if (i_pop_front_en)       w_pop_op = OP_POP_FRONT;
                else if (i_pop_back_en)   w_pop_op = OP_POP_BACK;
            end
        end
    end

    // NOTE: blocking assignments here build the next value step by step within one evaluation.
    always_comb begin
        w_head_next  = r_head;
        w_count_next = r_count;
        if (w_push_op == OP_PUSH_FRONT) w_head_next = w_head_next - lp_ptr_one;
        if (w_pop_op  == OP_POP_FRONT)  w_head_next = w_head_next + lp_ptr_one;
        if (w_push_op != OP_NONE)       w_count_next = w_count_next + lp_cnt_one;
        if (w_pop_op  != OP_NONE)       w_count_next = w_count_next - lp_cnt_one;

        // A simultaneous pop shifts the slot a push lands in: front pushes reuse the
        // popped head, back pushes reuse the popped tail.
        if (w_push_op == OP_PUSH_FRONT)
            w_wr_idx = (w_pop_op == OP_POP_FRONT) ? r_head : r_head - lp_ptr_one;
        else
            w_wr_idx = (w_pop_op == OP_POP_BACK) ? w_tail : r_head + w_count_lo;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_next;
            r_count <= w_count_next;
        end
    end

    assign o_push_rdy     = w_push_rdy;
    assign o_pop_rdy      = w_pop_rdy;
    assign o_wr_en        = (w_push_op != OP_NONE);
    assign o_wr_sel_front = (w_push_op == OP_PUSH_FRONT);
    assign o_wr_idx       = w_wr_idx;
    assign o_rd_front_idx = r_head;
    assign o_rd_back_idx  = w_tail;
    assign o_count        = r_count;

endmodule

// File: rtl/v2_op_centric_deque.sv
// Double-ended queue over a circular register file; control in v2_deque_ctrl,
// storage and read muxing here.
module v2_op_centric_deque
    import v2_deque_pkg::*;
#(
    parameter int unsigned p_depth    = DEPTH_DEFAULT,
    parameter int unsigned p_bitwidth = WIDTH_DEFAULT,
    localparam int unsigned lp_ptr_w  = $clog2(p_depth),
    localparam int unsigned lp_cnt_w  = lp_ptr_w + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push_back_en,
    output logic                  push_back_rdy,
    input  logic [p_bitwidth-1:0] push_back_data,
    input  logic                  push_front_en,
    output logic                  push_front_rdy,
    input  logic [p_bitwidth-1:0] push_front_data,
    input  logic                  pop_front_en,
    output logic                  pop_front_rdy,
    output logic [p_bitwidth-1:0] pop_front_data,
    input  logic                  pop_back_en,
    output logic                  pop_back_rdy,
    output logic [p_bitwidth-1:0] pop_back_data,
    output logic [lp_cnt_w-1:0]   count
);

    logic [p_bitwidth-1:0] r_mem [p_depth];

    logic                w_push_rdy;
    logic                w_pop_rdy;
    logic                w_wr_en;
    logic                w_wr_sel_front;
    logic [lp_ptr_w-1:0] w_wr_idx;
    logic [lp_ptr_w-1:0] w_rd_front_idx;
    logic [lp_ptr_w-1:0] w_rd_back_idx;

    v2_deque_ctrl #(
        .p_depth (p_depth)
    ) u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (clear),
        .i_push_back_en  (push_back_en),
        .i_push_front_en (push_front_en),
        .i_pop_front_en  (pop_front_en),
        .i_pop_back_en   (pop_back_en),
        .o_push_rdy      (w_push_rdy),
        .o_pop_rdy       (w_pop_rdy),
        .o_wr_en         (w_wr_en),
        .o_wr_sel_front  (w_wr_sel_front),
        .o_wr_idx        (w_wr_idx),
        .o_rd_front_idx  (w_rd_front_idx),
        .o_rd_back_idx   (w_rd_back_idx),
        .o_count         (count)
    );

    // NOTE: the register file is reset because cleared-to-zero storage is part of the reset state;
    // this is only viable because the array is small flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < p_depth; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_sel_front ? push_front_data : push_back_data;
        end
    end

    assign push_back_rdy  = w_push_rdy;
    assign push_front_rdy = w_push_rdy;
    assign pop_front_rdy  = w_pop_rdy;
    assign pop_back_rdy   = w_pop_rdy;

    // Stale entries stay in storage after a clear, so reads are masked when empty.
    assign pop_front_data = w_pop_rdy ? r_mem[w_rd_front_idx] : '0;
    assign pop_back_data  = w_pop_rdy ? r_mem[w_rd_back_idx]  : '0;

endmodule

// File: tb/tb_v2_op_centric_deque.sv
// Directed self-checking bench for v2_op_centric_deque (depth 8, width 32).
module tb_v2_op_centric_deque;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             push_back_en = 1'b0;
    logic             push_back_rdy;
    logic [WIDTH-1:0] push_back_data = '0;
    logic             push_front_en = 1'b0;
    logic             push_front_rdy;
    logic [WIDTH-1:0] push_front_data = '0;
    logic             pop_front_en = 1'b0;
    logic             pop_front_rdy;
    logic [WIDTH-1:0] pop_front_data;
    logic             pop_back_en = 1'b0;
    logic             pop_back_rdy;
    logic [WIDTH-1:0] pop_back_data;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    v2_op_centric_deque #(
        .p_depth    (DEPTH),
        .p_bitwidth (WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .push_back_en    (push_back_en),
        .push_back_rdy   (push_back_rdy),
        .push_back_data  (push_back_data),
        .push_front_en   (push_front_en),
        .push_front_rdy  (push_front_rdy),
        .push_front_data (push_front_data),
        .pop_front_en    (pop_front_en),
        .pop_front_rdy   (pop_front_rdy),
        .pop_front_data  (pop_front_data),
        .pop_back_en     (pop_back_en),
        .pop_back_rdy    (pop_back_rdy),
        .pop_back_data   (pop_back_data),
        .count           (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compares the full visible state against hand-computed count/front/back values.
    task automatic expect_state(input string tag, input int cnt, input logic [31:0] front,
                                input logic [31:0] back);
        check({tag, ".count"},    32'(count), 32'(cnt));
        check({tag, ".front"},    pop_front_data, front);
        check({tag, ".back"},     pop_back_data, back);
        check({tag, ".pb_rdy"},   32'(push_back_rdy),  32'(cnt != DEPTH));
        check({tag, ".pf_rdy"},   32'(push_front_rdy), 32'(cnt != DEPTH));
        check({tag, ".popf_rdy"}, 32'(pop_front_rdy),  32'(cnt != 0));
        check({tag, ".popb_rdy"}, 32'(pop_back_rdy),   32'(cnt != 0));
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic pbe, input logic [31:0] pbd, input logic pfe,
                         input logic [31:0] pfd, input logic pofe, input logic pobe,
                         input logic clr);
        push_back_en    = pbe;
        push_back_data  = pbd;
        push_front_en   = pfe;
        push_front_data = pfd;
        pop_front_en    = pofe;
        pop_back_en     = pobe;
        clear           = clr;
        @(posedge clk);
        #1;
        push_back_en  = 1'b0;
        push_front_en = 1'b0;
        pop_front_en  = 1'b0;
        pop_back_en   = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] d);
        cycle(1'b1, d, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_f(input logic [31:0] d);
        cycle(1'b0, '0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #12;
        expect_state("reset", 0, 0, 0);
        rst = 1'b1;

        push_b(32'hA); push_b(32'hB); push_b(32'hC);
        expect_state("pb3", 3, 32'hA, 32'hC);
        do_clear();
        expect_state("clear_masks_stale", 0, 0, 0);

        push_f(32'h55);
        expect_state("pf_wrap", 1, 32'h55, 32'h55);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_state("popf_unwrap", 0, 0, 0);
        push_b(32'h66);
        push_f(32'h67);
        expect_state("head_back_to_0", 2, 32'h67, 32'h66);
        do_clear();

        for (int i = 1; i <= 8; i++) push_f(32'(i));
        expect_state("full", 8, 32'd8, 32'd1);
        push_f(32'd9);
        expect_state("ninth_ignored", 8, 32'd8, 32'd1);
        cycle(1'b1, 32'h9, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_state("full_pop_alone", 7, 32'd7, 32'd1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        expect_state("pop_back", 6, 32'd7, 32'd2);
        do_clear();

        push_b(32'h11);
        cycle(1'b1, 32'h22, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_state("cnt1_pb_popf", 1, 32'h22, 32'h22);
        do_clear();

        cycle(1'b1, 32'h1, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        expect_state("both_push", 1, 32'h1, 32'h1);
        push_b(32'h3);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        expect_state("both_pop", 1, 32'h3, 32'h3);
        push_f(32'h44);
        expect_state("pf_after", 2, 32'h44, 32'h3);
        cycle(1'b0, '0, 1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
        expect_state("pf_popb", 2, 32'h66, 32'h44);
        cycle(1'b0, '0, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        expect_state("pf_popf", 2, 32'h77, 32'h44);
        cycle(1'b1, 32'h88, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        expect_state("pb_popb", 2, 32'h77, 32'h88);
        do_clear();

        cycle(1'b1, 32'h99, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        expect_state("empty_push_pop", 1, 32'h99, 32'h99);
        do_clear();

        for (int i = 1; i <= 5; i++) push_b(32'(i));
        expect_state("cnt5", 5, 32'd1, 32'd5);
        cycle(1'b1, 32'hAA, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        expect_state("clear_dominates", 0, 0, 0);

        push_b(32'h10); push_b(32'h20);
        push_back_en   = 1'b1;
        push_back_data = 32'h30;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        expect_state("async_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        expect_state("held_in_reset", 0, 0, 0);
        push_back_en = 1'b0;
        rst = 1'b1;
        push_f(32'h40);
        expect_state("after_reset", 1, 32'h40, 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
